seq_divider: RTL and testbench

- Iterative restoring unsigned divider; the inverse operation of the team's combinational array multiplier.
- Computes quotient and remainder of two WIDTH-bit unsigned operands, one quotient bit per clock, under a start/done handshake.
- Lab datapath building block; exhaustive results must satisfy quotient*divisor + remainder == dividend, checked against the existing multiplier.

---
 rtl/seq_divider.sv | 138 +++++++++++++
 tb/tb_seq_divider.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : Iterative restoring unsigned divider. Produces one quotient
//               bit per clock under a start/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_prem;
    logic [WIDTH-1:0] r_quo;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_prem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic             w_last;

    // The WIDTH+1-bit partial remainder only exists between shift and trial
    // subtract; after restore it is always below the divisor and fits WIDTH bits.
    always_comb begin
        w_shift     = {r_prem, r_dvd[WIDTH-1]};
        w_trial     = {1'b0, w_shift} - {2'b00, r_dvs};
        w_qbit      = ~w_trial[WIDTH+1];
        w_prem_next = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quo_next  = (r_quo << 1) | WIDTH'(w_qbit);
        w_last      = (r_count == c_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_quo       <= '0;
            r_count     <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dvd   <= dividend;
                        r_dvs   <= divisor;
                        r_prem  <= '0;
                        r_quo   <= '0;
                        r_count <= '0;
                        if (divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= dividend;
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_prem  <= w_prem_next;
                    r_quo   <= w_quo_next;
                    r_dvd   <= r_dvd << 1;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_quotient  <= w_quo_next;
                        r_remainder <= w_prem_next;
                        r_dbz       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking scoreboard bench for seq_divider (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Shift-and-add model of the team's array multiplier.
    function automatic logic [2*W-1:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] acc;
        acc = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) acc = acc + ({{W{1'b0}}, a} << i);
        end
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1; e.r = a; e.z = 1'b1;
        end else begin
            e.q = W'(a / b); e.r = W'(a % b); e.z = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   lat;
        int   nbusy;
        int   exp_lat;
        push_expected(a, b);
        exp_lat  = (b == '0) ? 0 : W;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 3 * W) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL done_timeout %0d/%0d: no done within %0d edges", a, b, lat);
            void'(sb.pop_front());
            return;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_errors++;
            $display("FAIL latency %0d/%0d: got %0d edges, want %0d", a, b, lat, exp_lat);
        end
        n_checks++;
        if (nbusy !== exp_lat) begin
            n_errors++;
            $display("FAIL busy_cycles %0d/%0d: got %0d, want %0d", a, b, nbusy, exp_lat);
        end
        e = sb.pop_front();
        n_checks++;
        if (quotient !== e.q) begin
            n_errors++;
            $display("FAIL quotient %0d/%0d: got %0d, want %0d", a, b, quotient, e.q);
        end
        n_checks++;
        if (remainder !== e.r) begin
            n_errors++;
            $display("FAIL remainder %0d/%0d: got %0d, want %0d", a, b, remainder, e.r);
        end
        n_checks++;
        if (div_by_zero !== e.z) begin
            n_errors++;
            $display("FAIL div_by_zero %0d/%0d: got %0b, want %0b", a, b, div_by_zero, e.z);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL done_pulse %0d/%0d: done=%0b busy=%0b, want 0 0", a, b, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags: busy/done/dbz=%b, want 000", {busy, done, div_by_zero});
        end
        n_checks++;
        if ({quotient, remainder} !== '0) begin
            n_errors++;
            $display("FAIL reset_results: q=%0d r=%0d, want 0 0", quotient, remainder);
        end
    endtask

    task automatic test_basic();
        run_op(4'd13, 4'd3);
        run_op(4'd15, 4'd1);
        run_op(4'd5,  4'd7);
        run_op(4'd9,  4'd0);
        run_op(4'd8,  4'd2);
    endtask

    task automatic test_abort();
        int ndone;
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
            n_errors++;
            $display("FAIL abort_outputs: busy=%0b done=%0b dbz=%0b q=%0d r=%0d, want all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_errors++;
            $display("FAIL abort_idle: got %0d active cycles after reset, want 0", ndone);
        end
        run_op(4'd14, 4'd3);
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           ph;
        start = 1'b1;
        for (int ed = 0; ed < 36; ed++) begin
            a = W'($urandom_range(0, 15));
            b = W'($urandom_range(1, 15));
            dividend = a;
            divisor  = b;
            if (ed % (W + 2) == 0) push_expected(a, b);
            tick();
            ph = ed % (W + 2);
            n_checks++;
            if (done !== (ph == W) || busy !== (ph < W)) begin
                n_errors++;
                $display("FAIL b2b_phase edge %0d: done=%0b busy=%0b, want %0b %0b",
                         ed, done, busy, (ph == W), (ph < W));
            end
            if (done && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                    n_errors++;
                    $display("FAIL b2b_result edge %0d: q=%0d r=%0d z=%0b, want %0d %0d %0b",
                             ed, quotient, remainder, div_by_zero, e.q, e.r, e.z);
                end
            end
        end
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (sb.size() !== 0) begin
            n_errors++;
            $display("FAIL b2b_pending: got %0d outstanding results, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_exhaustive();
        logic [2*W-1:0] recon;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                run_op(W'(a), W'(b));
                recon = mul_model(quotient, W'(b)) + {{W{1'b0}}, remainder};
                n_checks++;
                if (recon !== (2*W)'(a)) begin
                    n_errors++;
                    $display("FAIL identity %0d/%0d: q*d+r=%0d, want %0d", a, b, recon, a);
                end
                n_checks++;
                if (remainder >= W'(b)) begin
                    n_errors++;
                    $display("FAIL rem_bound %0d/%0d: r=%0d, want < %0d", a, b, remainder, b);
                end
            end
        end
    endtask

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_abort();
        test_back_to_back();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
